// File: rtl/qosc_sequencer_if.sv
// rtl/qosc_sequencer_if.sv - register write port and sample handshake bundle for qosc_sequencer
interface qosc_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] sample_re;
    logic [15:0] sample_im;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output wr_en, wr_addr, wr_data, sample_ready,
        input  sample_re, sample_im, sample_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, sample_ready,
        output sample_re, sample_im, sample_valid
    );
endinterface

// File: rtl/qosc_sequencer.sv
// rtl/qosc_sequencer.sv - oscillator preload, step pacing, atomic coefficient commit and sample capture
module qosc_sequencer (
    input  logic                clk,
    input  logic                rst_n,
    qosc_sequencer_if.slave     bus,
    output logic [15:0]         osc_re_coeff,
    output logic [15:0]         osc_im_coeff,
    output logic [15:0]         osc_power,
    output logic [15:0]         osc_re_init,
    output logic [15:0]         osc_im_init,
    output logic                osc_load,
    output logic                osc_step,
    input  logic [15:0]         osc_re,
    input  logic [15:0]         osc_im,
    output logic                running,
    output logic [7:0]          overflow_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t      state;
    logic [15:0] stg_re, stg_im, stg_pw, stg_ire, stg_iim, stg_d;
    logic [15:0] d_act;
    logic [15:0] cnt;
    logic        commit_pending;
    logic        cap_pend;

    logic ctl_wr, start_wr, stop_wr, commit_wr, clear_wr, coeff_load;

    // Control register strobes; stop masks a simultaneous start
    assign ctl_wr    = bus.wr_en && (bus.wr_addr == 4'hC);
    assign stop_wr   = ctl_wr && bus.wr_data[1];
    assign start_wr  = ctl_wr && bus.wr_data[0] && !bus.wr_data[1];
    assign commit_wr = ctl_wr && bus.wr_data[2];
    assign clear_wr  = ctl_wr && bus.wr_data[3];

    // Coefficients move on start, an immediate commit outside RUN, or the end of a step with a commit armed
    assign coeff_load = start_wr || (commit_wr && (state != RUN)) || (commit_pending && osc_step);

    // Staging registers written byte-wise, little-endian pairs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_re  <= '0;
            stg_im  <= '0;
            stg_pw  <= '0;
            stg_ire <= '0;
            stg_iim <= '0;
            stg_d   <= '0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                4'h0: stg_re[7:0]   <= bus.wr_data;
                4'h1: stg_re[15:8]  <= bus.wr_data;
                4'h2: stg_im[7:0]   <= bus.wr_data;
                4'h3: stg_im[15:8]  <= bus.wr_data;
                4'h4: stg_pw[7:0]   <= bus.wr_data;
                4'h5: stg_pw[15:8]  <= bus.wr_data;
                4'h6: stg_ire[7:0]  <= bus.wr_data;
                4'h7: stg_ire[15:8] <= bus.wr_data;
                4'h8: stg_iim[7:0]  <= bus.wr_data;
                4'h9: stg_iim[15:8] <= bus.wr_data;
                4'hA: stg_d[7:0]    <= bus.wr_data;
                4'hB: stg_d[15:8]   <= bus.wr_data;
                default: ;
            endcase
        end
    end

    // Active coefficient, preload and divider registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_re_coeff <= '0;
            osc_im_coeff <= '0;
            osc_power    <= '0;
            osc_re_init  <= '0;
            osc_im_init  <= '0;
            d_act        <= '0;
        end else begin
            if (coeff_load) begin
                osc_re_coeff <= stg_re;
                osc_im_coeff <= stg_im;
                osc_power    <= stg_pw;
            end
            if (start_wr) begin
                osc_re_init <= stg_ire;
                osc_im_init <= stg_iim;
                d_act       <= stg_d;
            end
        end
    end

    // Commit arming: a RUN-time commit waits for the next step to finish; start discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
        end else if (start_wr) begin
            commit_pending <= 1'b0;
        end else if (commit_wr && (state == RUN)) begin
            commit_pending <= 1'b1;
        end else if (commit_pending && osc_step) begin
            commit_pending <= 1'b0;
        end
    end

    // Sequencer FSM with registered load/step/running outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            osc_load <= 1'b0;
            osc_step <= 1'b0;
            running  <= 1'b0;
        end else if (stop_wr) begin
            state    <= IDLE;
            osc_load <= 1'b0;
            osc_step <= 1'b0;
            running  <= 1'b0;
        end else if (start_wr) begin
            state    <= LOAD;
            osc_load <= 1'b1;
            osc_step <= 1'b0;
            running  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    osc_load <= 1'b0;
                    osc_step <= 1'b0;
                    running  <= 1'b0;
                end
                LOAD: begin
                    state    <= RUN;
                    osc_load <= 1'b0;
                    cnt      <= d_act;
                    osc_step <= (d_act == 16'd0);
                end
                RUN: begin
                    if (cnt == 16'd0) begin
                        cnt      <= d_act;
                        osc_step <= (d_act == 16'd0);
                    end else begin
                        cnt      <= cnt - 16'd1;
                        osc_step <= (cnt == 16'd1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    osc_load <= 1'b0;
                    osc_step <= 1'b0;
                    running  <= 1'b0;
                end
            endcase
        end
    end

    // Sample capture one cycle after each step, with drop counting under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_pend         <= 1'b0;
            bus.sample_re    <= '0;
            bus.sample_im    <= '0;
            bus.sample_valid <= 1'b0;
            overflow_cnt     <= '0;
        end else begin
            cap_pend <= osc_step;
            if (cap_pend) begin
                if (!bus.sample_valid || bus.sample_ready) begin
                    bus.sample_re    <= osc_re;
                    bus.sample_im    <= osc_im;
                    bus.sample_valid <= 1'b1;
                end else if (overflow_cnt != 8'hFF) begin
                    overflow_cnt <= overflow_cnt + 8'd1;
                end
            end else if (bus.sample_valid && bus.sample_ready) begin
                bus.sample_valid <= 1'b0;
            end
            if (clear_wr) begin
                overflow_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_qosc_sequencer.sv
// tb/tb_qosc_sequencer.sv - self-checking bench for qosc_sequencer with behavioural oscillator and step-schedule model
module tb_qosc_sequencer;
    logic        clk;
    logic        rst_n;
    logic [15:0] osc_re_coeff, osc_im_coeff, osc_power, osc_re_init, osc_im_init;
    logic        osc_load, osc_step, running;
    logic [15:0] o_re, o_im;
    logic [7:0]  overflow_cnt;
    int          vec = 0;
    int          fail = 0;
    logic signed [15:0] gre [0:63];
    logic signed [15:0] gim [0:63];

    qosc_sequencer_if bus();

    qosc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .osc_re_coeff (osc_re_coeff),
        .osc_im_coeff (osc_im_coeff),
        .osc_power    (osc_power),
        .osc_re_init  (osc_re_init),
        .osc_im_init  (osc_im_init),
        .osc_load     (osc_load),
        .osc_step     (osc_step),
        .osc_re       (o_re),
        .osc_im       (o_im),
        .running      (running),
        .overflow_cnt (overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rot_re(input logic signed [15:0] re, im, cr, ci);
        longint p;
        p = longint'(re) * longint'(cr) - longint'(im) * longint'(ci);
        return 16'(p >>> 15);
    endfunction

    function automatic logic [15:0] rot_im(input logic signed [15:0] re, im, cr, ci);
        longint p;
        p = longint'(re) * longint'(ci) + longint'(im) * longint'(cr);
        return 16'(p >>> 15);
    endfunction

    // Behavioural oscillator driven by the sequencer
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_re <= '0;
            o_im <= '0;
        end else if (osc_load) begin
            o_re <= osc_re_init;
            o_im <= osc_im_init;
        end else if (osc_step) begin
            o_re <= rot_re(o_re, o_im, osc_re_coeff, osc_im_coeff);
            o_im <= rot_im(o_re, o_im, osc_re_coeff, osc_im_coeff);
        end
    end

    task automatic gen_golden(input logic [15:0] ire, iim, cr, ci);
        gre[0] = ire;
        gim[0] = iim;
        for (int i = 1; i < 64; i++) begin
            gre[i] = rot_re(gre[i-1], gim[i-1], cr, ci);
            gim[i] = rot_im(gre[i-1], gim[i-1], cr, ci);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic prog(input logic [15:0] cr, ci, pw, ire, iim, d);
        logic [15:0] v [0:5];
        v[0] = cr; v[1] = ci; v[2] = pw; v[3] = ire; v[4] = iim; v[5] = d;
        for (int i = 0; i < 6; i++) begin
            wr(4'(2*i), v[i][7:0]);
            wr(4'(2*i+1), v[i][15:8]);
        end
    endtask

    task automatic stop_drain();
        wr(4'hC, 8'h02);
        bus.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Called in the LOAD cycle; j counts cycles from LOAD, steps land where (j-1) mod (d+1) == d
    task automatic check_run(input int d, input int ncyc, input bit chk_s, input string tag);
        bit el, es, ev;
        int n;
        for (int j = 0; j < ncyc; j++) begin
            el = (j == 0);
            es = (j >= 1) && (((j - 1) % (d + 1)) == d);
            ev = (j >= 3) && (((j - 3) % (d + 1)) == d);
            vec++;
            if (osc_load !== el) begin fail++; $display("FAIL %s load j=%0d got %b exp %b", tag, j, osc_load, el); end
            vec++;
            if (osc_step !== es) begin fail++; $display("FAIL %s step j=%0d got %b exp %b", tag, j, osc_step, es); end
            vec++;
            if (running !== 1'b1) begin fail++; $display("FAIL %s running j=%0d got %b exp 1", tag, j, running); end
            if (chk_s) begin
                vec++;
                if (bus.sample_valid !== ev) begin fail++; $display("FAIL %s valid j=%0d got %b exp %b", tag, j, bus.sample_valid, ev); end
                if (ev) begin
                    n = (j - 2) / (d + 1);
                    vec++;
                    if (bus.sample_re !== gre[n] || bus.sample_im !== gim[n]) begin
                        fail++;
                        $display("FAIL %s sample j=%0d got %h/%h exp %h/%h", tag, j, bus.sample_re, bus.sample_im, gre[n], gim[n]);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    // sample_ready held low: first sample held, every later capture counted as a drop
    task automatic run_bp(input int d, input int ncyc, input string tag);
        int cap, exp_of;
        for (int j = 0; j < ncyc; j++) begin
            cap = (j >= 2) ? (j - 2) / (d + 1) : 0;
            exp_of = (cap == 0) ? 0 : ((cap - 1 > 255) ? 255 : cap - 1);
            vec++;
            if (overflow_cnt !== 8'(exp_of)) begin fail++; $display("FAIL %s ovf j=%0d got %0d exp %0d", tag, j, overflow_cnt, exp_of); end
            if (cap >= 1) begin
                vec++;
                if (bus.sample_valid !== 1'b1 || bus.sample_re !== gre[1] || bus.sample_im !== gim[1]) begin
                    fail++;
                    $display("FAIL %s held j=%0d got %b %h/%h exp 1 %h/%h", tag, j, bus.sample_valid, bus.sample_re, bus.sample_im, gre[1], gim[1]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vec++;
        if ({osc_load, osc_step, running, bus.sample_valid} !== 4'b0) begin
            fail++; $display("FAIL reset_ctl got %b exp 0000", {osc_load, osc_step, running, bus.sample_valid});
        end
        vec++;
        if ({osc_re_coeff, osc_im_coeff, osc_power, osc_re_init, osc_im_init} !== 80'd0) begin
            fail++; $display("FAIL reset_active got %h exp 0", {osc_re_coeff, osc_im_coeff, osc_power, osc_re_init, osc_im_init});
        end
        vec++;
        if ({bus.sample_re, bus.sample_im, overflow_cnt} !== 40'd0) begin
            fail++; $display("FAIL reset_sample got %h exp 0", {bus.sample_re, bus.sample_im, overflow_cnt});
        end
    endtask

    task automatic test_basic_run();
        prog(16'h7FF6, 16'h0648, 16'h4000, 16'h4000, 16'h0000, 16'd3);
        gen_golden(16'h4000, 16'h0000, 16'h7FF6, 16'h0648);
        wr(4'hC, 8'h01);
        vec++;
        if (osc_re_coeff !== 16'h7FF6 || osc_im_coeff !== 16'h0648 || osc_power !== 16'h4000) begin
            fail++; $display("FAIL basic_coeff got %h %h %h exp 7ff6 0648 4000", osc_re_coeff, osc_im_coeff, osc_power);
        end
        check_run(3, 30, 1'b1, "basic");
        stop_drain();
    endtask

    task automatic test_random_runs();
        logic [15:0] cr, ci, pw, ire, iim;
        int d;
        for (int r = 0; r < 5; r++) begin
            cr = 16'($urandom); ci = 16'($urandom); pw = 16'($urandom);
            ire = 16'($urandom); iim = 16'($urandom);
            d = (r == 0) ? 0 : int'($urandom_range(0, 4));
            prog(cr, ci, pw, ire, iim, 16'(d));
            gen_golden(ire, iim, cr, ci);
            wr(4'hC, 8'h01);
            vec++;
            if (osc_re_coeff !== cr || osc_im_coeff !== ci || osc_power !== pw || osc_re_init !== ire || osc_im_init !== iim) begin
                fail++; $display("FAIL rand_copy r=%0d got %h %h %h %h %h exp %h %h %h %h %h", r,
                    osc_re_coeff, osc_im_coeff, osc_power, osc_re_init, osc_im_init, cr, ci, pw, ire, iim);
            end
            check_run(d, 5 * (d + 1) + 6, 1'b1, "rand");
            vec++;
            if (overflow_cnt !== 8'd0) begin fail++; $display("FAIL rand_noovf got %0d exp 0", overflow_cnt); end
            stop_drain();
        end
    endtask

    task automatic test_commit();
        bit seen;
        logic [15:0] exp_c;
        prog(16'h1111, 16'h2222, 16'h3333, 16'h0100, 16'h0000, 16'd7);
        wr(4'hC, 8'h01);
        check_run(7, 12, 1'b0, "commit_pre");
        wr(4'h0, 8'hCD);
        vec++;
        if (osc_re_coeff !== 16'h1111) begin fail++; $display("FAIL commit_lo got %h exp 1111", osc_re_coeff); end
        wr(4'h1, 8'hAB);
        vec++;
        if (osc_re_coeff !== 16'h1111) begin fail++; $display("FAIL commit_hi got %h exp 1111", osc_re_coeff); end
        wr(4'hC, 8'h04);
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            exp_c = seen ? 16'hABCD : 16'h1111;
            vec++;
            if (osc_re_coeff !== exp_c) begin fail++; $display("FAIL commit_edge j=%0d got %h exp %h", j, osc_re_coeff, exp_c); end
            if (osc_step) seen = 1'b1;
            @(negedge clk);
        end
        stop_drain();
    endtask

    task automatic test_backpressure();
        int steps;
        prog(16'h7FF6, 16'h0648, 16'h4000, 16'h2000, 16'h1000, 16'd1);
        gen_golden(16'h2000, 16'h1000, 16'h7FF6, 16'h0648);
        bus.sample_ready = 1'b0;
        wr(4'hC, 8'h01);
        run_bp(1, 23, "bp");
        steps = 23 / 2;
        wr(4'hC, 8'h02);
        repeat (3) @(negedge clk);
        vec++;
        if (overflow_cnt !== 8'(steps - 1)) begin fail++; $display("FAIL bp_after_stop got %0d exp %0d", overflow_cnt, steps - 1); end
        wr(4'hC, 8'h08);
        vec++;
        if (overflow_cnt !== 8'd0) begin fail++; $display("FAIL bp_clear got %0d exp 0", overflow_cnt); end
        bus.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.sample_ready = 1'b0;
        prog(16'h7FF6, 16'h0648, 16'h4000, 16'h2000, 16'h1000, 16'd0);
        wr(4'hC, 8'h01);
        run_bp(0, 270, "sat");
        wr(4'hC, 8'h02);
        repeat (2) @(negedge clk);
        vec++;
        if (overflow_cnt !== 8'd255) begin fail++; $display("FAIL sat_hold got %0d exp 255", overflow_cnt); end
        wr(4'hC, 8'h08);
        vec++;
        if (overflow_cnt !== 8'd0) begin fail++; $display("FAIL sat_clear got %0d exp 0", overflow_cnt); end
        bus.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_control();
        wr(4'hC, 8'h03);
        for (int j = 0; j < 4; j++) begin
            vec++;
            if (running !== 1'b0 || osc_load !== 1'b0) begin fail++; $display("FAIL startstop j=%0d got %b%b exp 00", j, running, osc_load); end
            @(negedge clk);
        end
        prog(16'h7000, 16'h0100, 16'h0000, 16'h1234, 16'h5678, 16'd2);
        wr(4'hC, 8'h01);
        check_run(2, 8, 1'b0, "ctl_first");
        wr(4'h6, 8'hEF); wr(4'h7, 8'hBE);
        wr(4'h8, 8'hAD); wr(4'h9, 8'hDE);
        vec++;
        if (osc_re_init !== 16'h1234 || osc_im_init !== 16'h5678) begin
            fail++; $display("FAIL ctl_staged got %h %h exp 1234 5678", osc_re_init, osc_im_init);
        end
        wr(4'hC, 8'h01);
        vec++;
        if (osc_re_init !== 16'hBEEF || osc_im_init !== 16'hDEAD) begin
            fail++; $display("FAIL ctl_restart_init got %h %h exp beef dead", osc_re_init, osc_im_init);
        end
        check_run(2, 12, 1'b0, "ctl_restart");
        wr(4'hC, 8'h02);
        for (int j = 0; j < 6; j++) begin
            vec++;
            if (osc_step !== 1'b0 || running !== 1'b0 || osc_load !== 1'b0) begin
                fail++; $display("FAIL ctl_stop j=%0d got %b%b%b exp 000", j, osc_step, running, osc_load);
            end
            @(negedge clk);
        end
        bus.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        prog(16'h7FF6, 16'h0648, 16'h4000, 16'h4000, 16'h0000, 16'd0);
        wr(4'hC, 8'h01);
        check_run(0, 6, 1'b0, "arst_pre");
        #3;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({osc_load, osc_step, running, bus.sample_valid, overflow_cnt} !== 12'd0) begin
            fail++; $display("FAIL arst_ctl got %h exp 0", {osc_load, osc_step, running, bus.sample_valid, overflow_cnt});
        end
        vec++;
        if ({osc_re_coeff, osc_im_coeff, osc_power, osc_re_init, osc_im_init, bus.sample_re, bus.sample_im} !== 112'd0) begin
            fail++; $display("FAIL arst_data got nonzero exp 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            vec++;
            if (running !== 1'b0 || osc_step !== 1'b0 || osc_load !== 1'b0) begin
                fail++; $display("FAIL arst_idle j=%0d got %b%b%b exp 000", j, running, osc_step, osc_load);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = 4'h0;
        bus.wr_data      = 8'h00;
        bus.sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_random_runs();
        test_commit();
        test_backpressure();
        test_control();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
        $finish;
    end
endmodule
